// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter for 4-phase req/gnt handshakes with a return-to-zero gap between grants.
// Optional grant revocation after TIMEOUT cycles is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_handshake_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [2:0]   owner,
  output logic         busy,
  output logic         timeout
);

  if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("rr_handshake_arbiter: N must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, REVOKE} state_t;

  state_t       state, state_n;
  logic [2:0]   ptr, ptr_n, owner_n, sel;
  logic [N-1:0] gnt_n;
  logic         busy_n, timeout_n, found, req_owner;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  logic       cnt_hit;
  assign cnt_hit = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT);
`endif

  // First requester at or above ptr, wrapping; inner index kept constant per unrolled step.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (32'(ptr) + i) % N)) begin
          found = 1'b1;
          sel   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    req_owner = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (3'(j) == owner) req_owner = req[j];
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    ptr_n     = ptr;
    busy_n    = busy;
    timeout_n = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_n     = cnt;
`endif
    case (state)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        if (found) begin
          for (int unsigned j = 0; j < N; j++) gnt_n[j] = (3'(j) == sel);
          owner_n = sel;
          ptr_n   = (sel == 3'(N - 1)) ? 3'd0 : sel + 3'd1;
          busy_n  = 1'b1;
          state_n = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        // A release seen on the same edge as the limit wins over revocation.
        if (!req_owner) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          state_n = RELEASE;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt_hit) begin
          gnt_n     = '0;
          timeout_n = 1'b1;
          state_n   = REVOKE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
`endif
      end
      RELEASE: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      REVOKE: begin
        gnt_n = '0;
`ifdef RR_ARB_TIMEOUT_EN
        if (!req_owner) begin
          busy_n  = 1'b0;
          state_n = RELEASE;
        end
`else
        busy_n  = 1'b0;
        state_n = IDLE;
`endif
      end
      default: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter (N=4, TIMEOUT=4); covers both RR_ARB_TIMEOUT_EN builds.
module tb_rr_handshake_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [2:0] owner;
  logic       busy;
  logic       timeout;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  rr_handshake_arbiter #(.N(4), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [2:0] o,
                         input logic b, input logic t);
    chk({tag, ".gnt"},     32'(gnt),     32'(g));
    chk({tag, ".owner"},   32'(owner),   32'(o));
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [3:0] exp_g;

    // Reset state
    repeat (3) step();
    chk_all("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;

    step();
    chk_all("idle_noreq", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Single requester 2; ptr -> 3
    req = 4'b0100;
    step(); chk_all("single_grant", 4'b0100, 3'd2, 1'b1, 1'b0);
    step(); chk_all("single_hold",  4'b0100, 3'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_all("single_release", 4'b0000, 3'd2, 1'b0, 1'b0);
    step(); chk_all("single_idle",    4'b0000, 3'd2, 1'b0, 1'b0);

    // Drop in the granted cycle still yields one gnt cycle; ptr wraps 3 -> 0, then ptr=1
    req = 4'b0001;
    step(); chk_all("drop_grant", 4'b0001, 3'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_all("drop_release", 4'b0000, 3'd0, 1'b0, 1'b0);
    step();

    // ptr=1, req=1001 -> 3 first, then 0 after the gap
    req = 4'b1001;
    step(); chk_all("skip_grant3", 4'b1000, 3'd3, 1'b1, 1'b0);
    step(); chk_all("skip_hold3",  4'b1000, 3'd3, 1'b1, 1'b0);
    req = 4'b0001;
    step(); chk_all("skip_release", 4'b0000, 3'd3, 1'b0, 1'b0);
    step(); chk_all("skip_gap",     4'b0000, 3'd3, 1'b0, 1'b0);
    step(); chk_all("skip_grant0",  4'b0001, 3'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); step();

    // Async reset mid-grant, then 1-cycle grant after release
    req = 4'b0010;
    step(); chk_all("pre_rst_grant", 4'b0010, 3'd1, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1 chk_all("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step(); chk_all("post_rst_grant", 4'b0010, 3'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step(); step();

    // Fresh reset so ptr=0, then fairness with all four requesting
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      req = 4'b1111;
      step(); chk($sformatf("fair%0d.gnt", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("fair%0d.owner", k), 32'(owner), 32'(k % 4));
      step(); chk($sformatf("fair%0d.hold", k), 32'(gnt), 32'(exp_g));
      req = 4'b1111 & ~exp_g;
      step(); chk($sformatf("fair%0d.rel", k), 32'(gnt), 32'd0);
      req = 4'b1111;
      step(); chk($sformatf("fair%0d.gap", k), 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    step(); step();

`ifdef RR_ARB_TIMEOUT_EN
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step(); chk_all($sformatf("to_held%0d", k), 4'b0001, 3'd0, 1'b1, 1'b0);
    end
    step(); chk_all("to_revoke", 4'b0000, 3'd0, 1'b1, 1'b1);
    step(); chk_all("to_hold1",  4'b0000, 3'd0, 1'b1, 1'b0);
    step(); chk_all("to_hold2",  4'b0000, 3'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_all("to_release", 4'b0000, 3'd0, 1'b0, 1'b0);
    step(); chk_all("to_idle",    4'b0000, 3'd0, 1'b0, 1'b0);

    // Release on the same edge the limit is reached: normal path, no pulse
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step(); chk($sformatf("edge_held%0d", k), 32'(gnt), 32'h1);
    end
    req = 4'b0000;
    step(); chk_all("edge_release", 4'b0000, 3'd0, 1'b0, 1'b0);
`else
    req = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      step();
      chk($sformatf("noto_gnt%0d", k), 32'(gnt), 32'h1);
      chk($sformatf("noto_to%0d", k),  32'(timeout), 32'h0);
    end
    chk("noto_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step(); chk_all("noto_release", 4'b0000, 3'd0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // gnt must stay one-hot-or-zero and pass through zero when changing bit
  logic [3:0] gnt_prev = '0;
  always @(negedge clk) begin
    if ($countones(gnt) > 1)
      chk("onehot", 32'(gnt), 32'(gnt & ~(gnt - 4'd1)));
    if (gnt != '0 && gnt_prev != '0 && gnt != gnt_prev)
      chk("rtz_gap", 32'(gnt), 32'(gnt_prev));
    gnt_prev = gnt;
  end

endmodule

// File: doc/rr_handshake_arbiter.md
RR_HANDSHAKE_ARBITER -- requirements
Module: rr_handshake_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum GRANT cycles before revocation (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N  per-requester 4-phase request level.
REQ-006 SHALL have port gnt  output  N  one-hot-or-zero grant, registered.
REQ-007 SHALL have port owner  output  3  index of current/last grantee, registered.
REQ-008 SHALL have port busy  output  1  high in GRANT or REVOKE.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse on revocation.

Function
REQ-010 SHALL implement states IDLE, GRANT, RELEASE, REVOKE.
REQ-011 IDLE: if any req bit set, SHALL select the first set bit searching upward (wrapping) from ptr, drive gnt[sel]=1, owner=sel, enter GRANT on the same edge; grant latency exactly 1 cycle from req sampled high.
REQ-012 IDLE with req=0 SHALL stay in IDLE, gnt=0.
REQ-013 On entering GRANT, ptr SHALL become (sel+1) mod N.
REQ-014 GRANT: gnt SHALL hold while req[owner]=1; other req bits SHALL be ignored.
REQ-015 GRANT with req[owner]=0 sampled SHALL clear gnt and enter RELEASE.
REQ-016 RELEASE SHALL last exactly one cycle with gnt=0, then IDLE; no grant is issued in RELEASE (return-to-zero gap).
REQ-017 gnt SHALL never have more than one bit set, and never change bit position without passing through gnt=0 for at least one cycle.
REQ-018 A requester dropping req in the cycle it is granted SHALL still receive one cycle of gnt, then RELEASE.
REQ-019 Simultaneous requests SHALL be resolved only by ptr; with all N requesting continuously, grants SHALL rotate 0,1,...,N-1,0 (after reset).
REQ-020 owner SHALL retain its value in RELEASE and IDLE.
REQ-021 busy SHALL equal (state==GRANT || state==REVOKE), registered.

Reset
REQ-022 rst low SHALL immediately force state=IDLE, gnt=0, owner=0, ptr=0, busy=0, timeout=0, cycle counter=0, regardless of clk.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt asynchronously; first grant after rst release SHALL take 1 cycle from the first sampled req.
REQ-024 Release of rst SHALL take effect at the first rising clk edge after deassertion; no state change in that same edge beyond normal IDLE evaluation.

Configuration
REQ-025 Macro RR_ARB_TIMEOUT_EN SHALL compile in the timeout feature.
REQ-026 With RR_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering GRANT and increment each GRANT cycle; when it reaches TIMEOUT with req[owner] still 1, SHALL clear gnt, pulse timeout for one cycle, enter REVOKE.
REQ-027 REVOKE SHALL hold gnt=0 until req[owner] sampled 0, then go to RELEASE; ptr unchanged by revocation.
REQ-028 Without RR_ARB_TIMEOUT_EN: no counter, REVOKE unreachable, timeout tied 0, grant held indefinitely.
REQ-029 Grant dropped by requester on the same edge the counter reaches TIMEOUT SHALL take the normal RELEASE path, no timeout pulse.

Verification
REQ-030 Single requester: req=0b0100 at cycle 2 -> gnt=0b0100 at cycle 3, owner=2; req drops cycle 6 -> gnt=0 cycle 7, RELEASE cycle 7, IDLE cycle 8.
REQ-031 All-request fairness: req=0b1111 held, each requester drops req 2 cycles after grant -> grant order 0,1,2,3,0 with one gnt=0 cycle between each.
REQ-032 Contention with skip: ptr=1, req=0b1001 -> gnt=0b1000 (owner 3), next grant 0b0001.
REQ-033 Async reset mid-grant: gnt=0b0010, rst low between edges -> gnt=0 before next edge; after release req=0b0010 -> gnt in 1 cycle, owner=1.
REQ-034 Timeout (macro on, TIMEOUT=4): req=0b0001 held -> gnt high 4 cycles, then gnt=0, timeout=1 one cycle, busy=1 until req drops, then RELEASE, IDLE.
REQ-035 Timeout off (macro undefined): same stimulus as REQ-034 for 300 cycles -> gnt stays 0b0001, timeout never 1.
